// File: rtl/axi_burst_splitter.sv
// axi_burst_splitter
// Splits a linear read or write request of arbitrary beat count into AXI
// bursts that never exceed MAX_BURST beats and never cross a 4 KB page.
// Each burst is handed to a downstream master through a one-cycle start
// strobe; the burst descriptor (addr/len/id) is held stable until the
// master reports the burst finished by raising its ready again.

module axi_burst_splitter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 24,
  parameter int MAX_BURST  = 256
) (
  input  logic                  i_axi_clk,
  input  logic                  i_axi_rst,

  // Request port
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_beats,
  input  logic [ID_WIDTH-1:0]   i_cmd_id,

  // Status
  output logic                  o_busy,
  output logic                  o_done,

  // Downstream burst master
  input  logic                  i_m_ready,
  output logic                  o_m_start_read_stb,
  output logic                  o_m_start_write_stb,
  output logic [ID_WIDTH-1:0]   o_m_id,
  output logic [ADDR_WIDTH-1:0] o_m_addr,
  output logic [7:0]            o_m_data_len
);

  localparam int BPB      = DATA_WIDTH / 8;
  localparam int BPB_LOG2 = $clog2(BPB);
  // Wide enough for both the beat count and a 13-bit page-beat count.
  localparam int CW       = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BPB - 1);
  localparam logic [8:0]            MAX_B     = 9'(MAX_BURST);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    WAIT_LOW,
    WAIT_DONE
  } state_t;

  state_t                state_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [8:0]            burst_q;
  logic                  done_q;

  logic [12:0]           page_bytes;
  logic [12:0]           page_beats;
  logic [CW-1:0]         remaining_ext;
  logic [8:0]            page_lim;
  logic [8:0]            remaining_lim;
  logic [8:0]            burst_c;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic [LEN_WIDTH-1:0]  remaining_next;
  logic                  issue_go;

  // Size of the next burst: the smallest of beats left, MAX_BURST and the
  // beats remaining before the next 4 KB page boundary.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    page_bytes    = 13'd4096 - {1'b0, addr_q[11:0]};
    page_beats    = page_bytes >> BPB_LOG2;
    remaining_ext = CW'(remaining_q);
    page_lim      = (page_beats >= 13'd256) ? 9'd256 : page_beats[8:0];
    remaining_lim = (remaining_ext >= CW'(256)) ? 9'd256 : remaining_ext[8:0];
    burst_c       = remaining_lim;
    if (page_lim < burst_c) begin
      burst_c = page_lim;
    end
    if (MAX_B < burst_c) begin
      burst_c = MAX_B;
    end
  end

  // Pointer and count advance once the master has finished the burst.
  assign burst_bytes    = ADDR_WIDTH'(burst_q) << BPB_LOG2;
  assign remaining_next = remaining_q - LEN_WIDTH'(burst_q);

  // Handshake and strobes are combinational so the master sees the strobe
  // in the same cycle its ready is observed high.
  assign o_cmd_ready         = (state_q == IDLE) & i_axi_rst;
  assign o_busy              = (state_q != IDLE);
  assign o_done              = done_q;
  assign issue_go            = (state_q == ISSUE) & i_m_ready;
  assign o_m_start_write_stb = issue_go & write_q;
  assign o_m_start_read_stb  = issue_go & ~write_q;

  // Request sequencer: accept, size each burst, issue it, wait for the
  // master to drop and re-raise ready, then advance or finish.
  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    // NOTE: all state, including the descriptor outputs, is cleared by
    // reset; there are no memories here that would be left unreset.
    if (!i_axi_rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      remaining_q  <= '0;
      id_q         <= '0;
      burst_q      <= '0;
      done_q       <= 1'b0;
      o_m_addr     <= '0;
      o_m_data_len <= '0;
      o_m_id       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_cmd_valid) begin
            write_q     <= i_cmd_write;
            addr_q      <= i_cmd_addr & ADDR_MASK;
            remaining_q <= i_cmd_beats;
            id_q        <= i_cmd_id;
            state_q     <= CALC;
          end
        end

        CALC: begin
          if (remaining_q == '0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            burst_q      <= burst_c;
            o_m_addr     <= addr_q;
            o_m_data_len <= 8'(burst_c - 9'd1);
            o_m_id       <= id_q;
            state_q      <= ISSUE;
          end
        end

        ISSUE: begin
          if (i_m_ready) begin
            state_q <= WAIT_LOW;
          end
        end

        // The master still shows ready in the strobe's following cycle.
        WAIT_LOW: begin
          state_q <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (i_m_ready) begin
            addr_q      <= addr_q + burst_bytes;
            remaining_q <= remaining_next;
            if (remaining_next == '0) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= CALC;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_burst_splitter.md
AXI_BURST_SPLITTER -- requirements
Module: axi_burst_splitter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, AXI data width in bits; bytes per beat BPB = DATA_WIDTH/8.
REQ-002 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 Parameter ID_WIDTH, default 4, transaction ID width.
REQ-004 Parameter LEN_WIDTH, default 24, width of the total-beat count.
REQ-005 Parameter MAX_BURST, default 256, maximum beats per burst; legal range 1..256.
REQ-006 i_axi_clk  in  1  single clock; all logic is on its rising edge.
REQ-007 i_axi_rst  in  1  reset, asynchronous, active-low; there is no polarity parameter.
REQ-008 i_cmd_valid  in  1  request valid.
REQ-009 o_cmd_ready  out  1  request accepted when i_cmd_valid & o_cmd_ready.
REQ-010 i_cmd_write  in  1  1 = write, 0 = read.
REQ-011 i_cmd_addr  in  ADDR_WIDTH  start byte address; bits below log2(BPB) are ignored (treated as 0).
REQ-012 i_cmd_beats  in  LEN_WIDTH  total beats; 0 is legal.
REQ-013 i_cmd_id  in  ID_WIDTH  ID used for every burst of the request.
REQ-014 o_busy  out  1  high whenever state != IDLE.
REQ-015 o_done  out  1  one-cycle pulse when the request has fully completed.
REQ-016 i_m_ready  in  1  downstream master idle (its o_ready).
REQ-017 o_m_start_read_stb, o_m_start_write_stb  out  1 each  burst start strobes.
REQ-018 o_m_id  out  ID_WIDTH; o_m_addr  out  ADDR_WIDTH; o_m_data_len  out  8 (beats-1).

Function
REQ-019 States: IDLE, CALC, ISSUE, WAIT_LOW, WAIT_DONE.
REQ-020 o_cmd_ready = (state==IDLE) & reset deasserted; on accept, latch write, addr, beats (as remaining), and id; go to CALC.
REQ-021 CALC: burst = min(remaining, MAX_BURST, (4096 - addr[11:0])/BPB); register o_m_addr=addr, o_m_data_len=burst-1, o_m_id; go to ISSUE; if remaining==0, pulse o_done next cycle and go to IDLE with no strobe.
REQ-022 ISSUE: strobe (read or write per latched flag) = (state==ISSUE) & i_m_ready, combinational; exactly one strobe, one cycle, per burst; go to WAIT_LOW on the strobe cycle; stay in ISSUE while i_m_ready=0.
REQ-023 The two strobes are never high in the same cycle.
REQ-024 WAIT_LOW lasts exactly one cycle and ignores i_m_ready (the master drops ready one cycle after the strobe).
REQ-025 WAIT_DONE: on i_m_ready=1: addr += burst*BPB and remaining -= burst (both modulo width); if the new remaining is 0, o_done=1 for the next cycle and go to IDLE; else go to CALC.
REQ-026 o_m_addr, o_m_data_len, and o_m_id stay stable from CALC exit until WAIT_DONE exit, because the master samples them combinationally for the whole burst.
REQ-027 No burst crosses a 4 KB boundary; no burst exceeds MAX_BURST beats.
REQ-028 A new i_cmd_valid during a request is not accepted (o_cmd_ready=0); the request stays pending on the port.
REQ-029 Address wraparound at 2^ADDR_WIDTH is not detected; the address wraps silently.

Reset
REQ-030 When i_axi_rst=0, immediately: state=IDLE; o_busy, o_done, both strobes, o_cmd_ready=0; o_m_addr, o_m_data_len, o_m_id, and internal counters=0.
REQ-031 Reset mid-request abandons it without an o_done pulse; the first cycle after release has o_cmd_ready=1.

Verification
REQ-032 Read, addr 0x1000, beats 16, i_m_ready=1 -> one read strobe, o_m_addr=0x1000, len=15; o_done after ready returns.
REQ-033 Write, addr 0x0, beats 600 -> three write strobes: (0x000, len 255), (0x400, len 255), (0x800, len 87); single o_done.
REQ-034 Read, addr 0x0FF0, beats 8, BPB=4 -> bursts (0x0FF0, len 3), (0x1000, len 3).
REQ-035 Beats 0 -> no strobe; o_done high exactly one cycle, two cycles after accept.
REQ-036 i_m_ready held 0 for 10 cycles in ISSUE -> no strobe and stable addr/len; strobe on the first cycle i_m_ready=1.
REQ-037 Reset asserted in WAIT_DONE -> all outputs 0 asynchronously, no o_done; o_cmd_ready=1 after release.
